// File: rtl/spi_master_sched.sv
// Round-robin arbiter in front of a single 8-bit SPI master engine.
// Each grant runs one full-duplex byte to the granted requester's slave, then the pointer advances.
//
// state | meaning
// IDLE  | CS all high, waiting for any req
// SETUP | CS low, SCLK at CPOL for CLK_DIV cycles
// SHIFT | 16 SCLK edges, one every CLK_DIV cycles
// HOLD  | SCLK back at CPOL, CS still low for CLK_DIV cycles
// DONE  | CS released, done_pulse, rx_data updated
module spi_master_sched #(
  parameter logic [1:0] MODE    = 2'd3,
  parameter int         CLK_DIV = 4,
  parameter int         NREQ    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   tx_data,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                done_pulse,
  output logic [7:0]          rx_data,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO,
  output logic [NREQ-1:0]     CS
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(NREQ);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [4:0]      edge_cnt;
  logic [4:0]      edge_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [7:0]      pick_byte;
  logic [7:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic            leading;
  logic            drive_edge;
  logic            sample_edge;

  // Walk downward so the requester closest above the pointer is the last (winning) hit.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh   = NREQ'(1) << pick_idx;
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_byte = tx_data[8*i +: 8];
    end
  end

  always_comb begin
    edge_nxt    = edge_cnt + 5'd1;
    leading     = edge_nxt[0];
    // CPHA=0 keeps bit0 on the line after the last trailing edge.
    drive_edge  = CPHA ? leading : (!leading && edge_nxt != 5'd16);
    sample_edge = CPHA ? !leading : leading;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      rx_data    <= '0;
      SCLK       <= CPOL;
      MOSI       <= 1'b0;
      CS         <= '1;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= SETUP;
            gnt      <= pick_oh;
            CS       <= ~pick_oh;
            busy     <= 1'b1;
            gnt_idx  <= pick_idx;
            div_cnt  <= DIV_LOAD;
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (CPHA) begin
              tx_sr <= pick_byte;
              MOSI  <= 1'b0;
            end else begin
              tx_sr <= {pick_byte[6:0], 1'b0};
              MOSI  <= pick_byte[7];
            end
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            state   <= SHIFT;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt  <= DIV_LOAD;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_nxt;
            if (drive_edge) begin
              MOSI  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sample_edge) rx_sr <= {rx_sr[6:0], MISO};
            if (edge_nxt == 5'd16) state <= HOLD;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        HOLD: begin
          if (div_cnt == '0) begin
            state      <= DONE;
            CS         <= '1;
            gnt        <= '0;
            done_pulse <= 1'b1;
            rx_data    <= rx_sr;
            rr_ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Three scheduler instances (mode 3 / div 4, mode 0 / div 4, mode 1 / div 1) checked
// every cycle against a transfer-timeline model plus directed literal expectations.
module tb_spi_master_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_v  [3];
  logic [31:0] tx_v  [3];
  logic [3:0] gnt_v  [3];
  logic [3:0] cs_v   [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic [7:0] rx_v   [3];
  logic       sclk_v [3];
  logic       mosi_v [3];
  logic       miso_a, miso_b, miso_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign miso_a = mosi_v[0];
  assign miso_c = mosi_v[2];

  spi_master_sched #(.MODE(2'd3), .CLK_DIV(4), .NREQ(4)) u_a (
    .clk(clk), .rst(rst), .req(req_v[0]), .tx_data(tx_v[0]), .gnt(gnt_v[0]),
    .busy(busy_v[0]), .done_pulse(done_v[0]), .rx_data(rx_v[0]), .SCLK(sclk_v[0]),
    .MOSI(mosi_v[0]), .MISO(miso_a), .CS(cs_v[0]));

  spi_master_sched #(.MODE(2'd0), .CLK_DIV(4), .NREQ(4)) u_b (
    .clk(clk), .rst(rst), .req(req_v[1]), .tx_data(tx_v[1]), .gnt(gnt_v[1]),
    .busy(busy_v[1]), .done_pulse(done_v[1]), .rx_data(rx_v[1]), .SCLK(sclk_v[1]),
    .MOSI(mosi_v[1]), .MISO(miso_b), .CS(cs_v[1]));

  spi_master_sched #(.MODE(2'd1), .CLK_DIV(1), .NREQ(4)) u_c (
    .clk(clk), .rst(rst), .req(req_v[2]), .tx_data(tx_v[2]), .gnt(gnt_v[2]),
    .busy(busy_v[2]), .done_pulse(done_v[2]), .rx_data(rx_v[2]), .SCLK(sclk_v[2]),
    .MOSI(mosi_v[2]), .MISO(miso_c), .CS(cs_v[2]));

  int    cd   [3] = '{4, 4, 1};
  bit    cpol [3] = '{1'b1, 1'b0, 1'b0};
  bit    cpha [3] = '{1'b1, 1'b0, 1'b1};
  string nm   [3] = '{"a", "b", "c"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  // Slave for instance b: mode 0, presents 8'h3C MSB first, advancing on SCLK falling edges.
  logic [7:0] pat_b = 8'h3C;
  initial begin
    int  bcnt;
    logic sprev;
    miso_b = 1'b0;
    bcnt   = 0;
    sprev  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cs_v[1] == 4'hF) begin
        bcnt   = 0;
        miso_b = pat_b[7];
      end else if (sprev && !sclk_v[1] && bcnt < 7) begin
        bcnt++;
        miso_b = pat_b[7 - bcnt];
      end
      sprev = sclk_v[1];
    end
  end

  // Model: a grant at cycle t=0 keeps CS low for t < 18*cd, edge k lands at t=(k+1)*cd, DONE at t=18*cd.
  bit         act [3];
  int         tm  [3];
  int         gi  [3];
  int         rrm [3];
  logic [7:0] byt [3];
  logic [7:0] lrx [3];

  initial begin
    logic       rst_s;
    logic [3:0] req_s [3];
    logic [31:0] tx_s [3];
    for (int k = 0; k < 3; k++) begin
      act[k] = 0; tm[k] = 0; gi[k] = 0; rrm[k] = 0; byt[k] = 0; lrx[k] = 0;
    end
    forever begin
      @(posedge clk);
      rst_s = rst;
      for (int k = 0; k < 3; k++) begin
        req_s[k] = req_v[k];
        tx_s[k]  = tx_v[k];
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic [3:0] e_cs, e_g;
        logic       e_busy, e_done, e_sclk, e_mosi;
        int         e, idx;
        if (rst || rst_s) begin
          act[k] = 0; rrm[k] = 0; lrx[k] = 0;
        end else if (act[k]) begin
          tm[k]++;
          if (tm[k] > 18 * cd[k]) act[k] = 0;
          else if (tm[k] == 18 * cd[k]) begin
            rrm[k] = (gi[k] + 1) % 4;
            lrx[k] = (k == 1) ? 8'h3C : byt[k];
          end
        end else if (req_s[k] != 4'h0) begin
          gi[k]  = pick(req_s[k], rrm[k]);
          act[k] = 1;
          tm[k]  = 0;
          byt[k] = tx_s[k][8*gi[k] +: 8];
        end
        e_cs = 4'hF; e_g = 4'h0; e_busy = 0; e_done = 0; e_sclk = cpol[k]; e_mosi = 0;
        if (act[k] && tm[k] < 18 * cd[k]) begin
          e_g    = 4'b0001 << gi[k];
          e_cs   = ~e_g;
          e_busy = 1;
          e = tm[k] / cd[k] - 1;
          if (e < 0) e = 0;
          e_sclk = cpol[k] ^ e[0];
          if (!cpha[k]) begin
            idx = e / 2;
            if (idx > 7) idx = 7;
            e_mosi = byt[k][7 - idx];
          end else if (e > 0) begin
            idx = (e - 1) / 2;
            e_mosi = byt[k][7 - idx];
          end
          check($sformatf("%s_mosi", nm[k]), 32'(mosi_v[k]), 32'(e_mosi));
        end else if (act[k]) begin
          e_busy = 1;
          e_done = 1;
        end
        check($sformatf("%s_cs", nm[k]),   32'(cs_v[k]),   32'(e_cs));
        check($sformatf("%s_gnt", nm[k]),  32'(gnt_v[k]),  32'(e_g));
        check($sformatf("%s_busy", nm[k]), 32'(busy_v[k]), 32'(e_busy));
        check($sformatf("%s_done", nm[k]), 32'(done_v[k]), 32'(e_done));
        check($sformatf("%s_sclk", nm[k]), 32'(sclk_v[k]), 32'(e_sclk));
        check($sformatf("%s_rx", nm[k]),   32'(rx_v[k]),   32'(lrx[k]));
      end
    end
  end

  // Follows one transfer of instance k from CS fall to done_pulse, recording what was seen on the wire.
  task automatic observe(input int k, output int idle_cyc, output int cs_low, output int n_edges,
                         output logic [7:0] cap, output logic [3:0] g, output logic [7:0] rx_d);
    bit   got;
    logic prev;
    idle_cyc = 0; cs_low = 0; n_edges = 0; cap = 0; g = 0; rx_d = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (cs_v[k] != 4'hF) got = 1;
      else idle_cyc++;
    end
    check($sformatf("%s_cs_fall_seen", nm[k]), 32'(got), 32'd1);
    if (!got) return;
    cs_low = 1;
    g      = gnt_v[k];
    prev   = sclk_v[k];
    got    = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (sclk_v[k] != prev) begin
        n_edges++;
        if (sclk_v[k] == (cpol[k] == cpha[k])) cap = {cap[6:0], mosi_v[k]};
      end
      prev = sclk_v[k];
      if (done_v[k]) begin
        got  = 1;
        rx_d = rx_v[k];
      end else if (cs_v[k] != 4'hF) cs_low++;
    end
    check($sformatf("%s_done_seen", nm[k]), 32'(got), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         idle, csl, ne, cnt;
    logic [7:0] cap, rxd;
    logic [3:0] g;
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_rx  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    bit         got;
    logic       prev;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v[k] = 4'h0;
      tx_v[k]  = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_cs",   32'(cs_v[0]),   32'hF);
    check("reset_sclk", 32'(sclk_v[0]), 32'd1);
    check("reset_mosi", 32'(mosi_v[0]), 32'd0);
    check("reset_rx",   32'(rx_v[0]),   32'h0);

    // All requesters active: rotation 0,1,2,3,0 with a CS-high gap between transfers.
    tx_v[0]  = 32'h44332211;
    req_v[0] = 4'hF;
    for (int n = 0; n < 5; n++) begin
      observe(0, idle, csl, ne, cap, g, rxd);
      if (n == 4) req_v[0] = 4'h0;
      check($sformatf("rr_gnt%0d", n), 32'(g),   32'(exp_seq[n]));
      check($sformatf("rr_rx%0d", n),  32'(rxd), 32'(exp_rx[n]));
      if (n > 0) check($sformatf("rr_gap%0d", n), 32'(idle), 32'd1);
    end
    repeat (4) @(posedge clk);

    // Mode 3 loopback of 8'hA5 on requester 0.
    #1 tx_v[0][7:0] = 8'hA5;
    req_v[0] = 4'b0001;
    observe(0, idle, csl, ne, cap, g, rxd);
    req_v[0] = 4'h0;
    check("t1_cs_low", 32'(csl), 32'd72);
    check("t1_edges",  32'(ne),  32'd16);
    check("t1_mosi",   32'(cap), 32'hA5);
    check("t1_gnt",    32'(g),   32'b0001);
    check("t1_rx",     32'(rxd), 32'hA5);
    @(posedge clk); #1;
    check("t1_gnt_clear", 32'(gnt_v[0]), 32'h0);

    // Mode 0 with an external slave returning 8'h3C.
    check("t2_sclk_idle_pre", 32'(sclk_v[1]), 32'd0);
    tx_v[1][7:0] = 8'h96;
    req_v[1] = 4'b0001;
    observe(1, idle, csl, ne, cap, g, rxd);
    req_v[1] = 4'h0;
    check("t2_cs_low", 32'(csl), 32'd72);
    check("t2_edges",  32'(ne),  32'd16);
    check("t2_mosi",   32'(cap), 32'h96);
    check("t2_rx",     32'(rxd), 32'h3C);
    repeat (3) @(posedge clk); #1;
    check("t2_sclk_idle_post", 32'(sclk_v[1]), 32'd0);

    // Reset after the 7th SCLK edge aborts the transfer; the pointer restarts at 0.
    tx_v[0][23:16] = 8'hC3;
    req_v[0] = 4'b0100;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (cs_v[0] != 4'hF) got = 1;
    end
    check("t4_abort_gnt", 32'(gnt_v[0]), 32'b0100);
    prev = sclk_v[0];
    cnt  = 0;
    for (int i = 0; i < 200 && cnt < 7; i++) begin
      @(posedge clk); #1;
      if (sclk_v[0] != prev) cnt++;
      prev = sclk_v[0];
    end
    check("t4_edges_before_rst", 32'(cnt), 32'd7);
    rst = 1'b1;
    #1;
    check("t4_rst_sclk", 32'(sclk_v[0]), 32'd1);
    check("t4_rst_cs",   32'(cs_v[0]),   32'hF);
    check("t4_rst_gnt",  32'(gnt_v[0]),  32'h0);
    check("t4_rst_busy", 32'(busy_v[0]), 32'd0);
    check("t4_rst_rx",   32'(rx_v[0]),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_v[0][7:0] = 8'h3E;
    req_v[0] = 4'b0101;
    observe(0, idle, csl, ne, cap, g, rxd);
    req_v[0] = 4'h0;
    check("t4_restart_gnt", 32'(g),   32'b0001);
    check("t4_restart_rx",  32'(rxd), 32'h3E);
    repeat (3) @(posedge clk);

    // req dropped and tx_data changed mid-transfer; the latched 8'h81 still goes out.
    #1 tx_v[0][23:16] = 8'h81;
    req_v[0] = 4'b0100;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt_v[0] != 4'h0) got = 1;
    end
    check("t5_gnt", 32'(gnt_v[0]), 32'b0100);
    req_v[0] = 4'h0;
    repeat (20) @(posedge clk);
    #1 tx_v[0][23:16] = 8'hFF;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) got = 1;
    end
    check("t5_done", 32'(got), 32'd1);
    check("t5_rx",   32'(rx_v[0]), 32'h81);
    repeat (3) @(posedge clk);

    // CLK_DIV=1, mode 1: back-to-back transfers on requester 2.
    #1 tx_v[2][23:16] = 8'h5A;
    req_v[2] = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      observe(2, idle, csl, ne, cap, g, rxd);
      if (n == 2) req_v[2] = 4'h0;
      check($sformatf("t6_cs_low%0d", n), 32'(csl), 32'd18);
      check($sformatf("t6_edges%0d", n),  32'(ne),  32'd16);
      check($sformatf("t6_mosi%0d", n),   32'(cap), 32'h5A);
      check($sformatf("t6_rx%0d", n),     32'(rxd), 32'h5A);
      if (n > 0) check($sformatf("t6_gap%0d", n), 32'(idle), 32'd1);
    end
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
